pulse_scan_ctrl: RTL and testbench
==================================

# pulse_scan_ctrl

Threshold-scan sequencer for the pulse counter. It steps the differential threshold through a programmed ramp and gates the counter's count enable for one measurement window per step. It captures each window total into a small result FIFO that is drained over a valid/ready handshake. The block sits between the host configuration registers and the pulse counter's threshold, window and enable inputs.

## Interface
- DATA_WIDTH, 20, threshold width (signed Q16.4)
- COUNTER_WIDTH, 24, pulse count width
- STEP_W, 5, width of step count and index (max 31 steps)
- FIFO_DEPTH, 4, result FIFO entries (power of two)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle scan start pulse; honoured only in IDLE
- abort  in  1  one-cycle abort pulse; honoured in every state
- cfg_thr_start  in  DATA_WIDTH  signed diff threshold of step 0
- cfg_thr_step  in  DATA_WIDTH  signed increment per step
- cfg_abs_thr  in  DATA_WIDTH  abs threshold, constant for the whole scan
- cfg_num_steps  in  STEP_W  number of steps; 0 is treated as 1
- cfg_window  in  24  window length in cycles, passed through
- cfg_settle  in  8  flush cycles after each threshold change; values below 16 are forced to 16
- diff_threshold  out  DATA_WIDTH  to counter
- abs_threshold  out  DATA_WIDTH  to counter
- window_cycles  out  24  to counter
- count_enable  out  1  to counter
- cnt_pulse_count  in  COUNTER_WIDTH  from counter
- cnt_count_valid  in  1  from counter, one-cycle pulse per window
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer accepts the head entry
- res_step  out  STEP_W  step index of the head entry
- res_thr  out  DATA_WIDTH  threshold of the head entry
- res_count  out  COUNTER_WIDTH  pulse count of the head entry
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse when the final step is pushed

## Operation
- FSM states: IDLE, LOAD, SETTLE, COUNT, PUSH.
- IDLE:
  - On start, latch all cfg_* inputs and go to LOAD with step=0 and thr=cfg_thr_start.
  - cfg_* changes during a scan are ignored.
- LOAD: drive diff_threshold=thr, abs_threshold and window_cycles; count_enable=0. Next state SETTLE.
- SETTLE: count_enable=0 for the effective settle count (cfg_settle, minimum 16), then go to COUNT.
- COUNT:
  - count_enable=1.
  - On cnt_count_valid, capture cnt_pulse_count, deassert count_enable in the same cycle's register update, and go to PUSH.
- PUSH:
  - If the FIFO is not full, write {step, thr, count}.
  - If step equals num_steps-1, pulse done and go to IDLE.
  - Otherwise step+1, thr = sat(thr + cfg_thr_step), and go to LOAD.
  - If the FIFO is full, stay in PUSH until space frees. count_enable stays 0 while waiting.
- Threshold add: DATA_WIDTH+1-bit signed sum, saturated to the signed min/max of DATA_WIDTH.
- FIFO:
  - A pop (res_valid && res_ready) and a push in the same cycle are both performed.
  - When full, a pop frees space in that same cycle, so a simultaneous push succeeds.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a counter of log2(FIFO_DEPTH)+1 bits.
- abort:
  - The next state is IDLE, count_enable drops on the next edge, and no done is issued.
  - The FIFO is flushed (res_valid=0 the next cycle).
  - If abort and start arrive together in IDLE, abort wins.
- cnt_count_valid outside COUNT is ignored.

## Timing
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - The FIFO is empty.
- start to LOAD: 1 cycle. start to count_enable high: 2 + effective settle cycles.
- count_valid to push: the FIFO write happens on the cycle after count_valid, provided the FIFO has space.
- PUSH to the next LOAD: 1 cycle.
- Result outputs come from registered FIFO head reads. res_* is stable while res_valid && !res_ready.

## Configuration
- SCAN_DISCARD_FIRST_EN:
  - Defined: each step ignores the first cnt_count_valid after count_enable rises, because that window straddles the enable edge. The second count_valid is the one captured, so each step costs two windows.
  - Undefined: the first count_valid is captured.

## Structure
- Package pulse_scan_pkg holds:
  - the FSM state enum;
  - the result entry struct {step, thr, count};
  - the constant MIN_SETTLE=16;
  - the saturating-add function.
- Sub-module scan_result_fifo: a synchronous FIFO parameterized by entry width and FIFO_DEPTH, with full/empty flags.

## Test plan
- Basic scan:
  - Stimulus: num_steps=3, thr_start=100, step=50, window=64, counter model returns 7/9/11, res_ready=1.
  - Required: three results {0,100,7},{1,150,9},{2,200,11}; done one cycle after the third push.
- Saturation:
  - Stimulus: thr_start=0x7FF00, step=0x00200, num_steps=3.
  - Required: step 1 and step 2 thresholds are both 0x7FFFF.
- FIFO backpressure:
  - Stimulus: FIFO_DEPTH=4, num_steps=6, res_ready=0.
  - Required: the scan stalls in PUSH at step 4 with count_enable=0. Raising res_ready resumes the scan, and all 6 results arrive in order.
- Abort mid-COUNT:
  - Stimulus: abort asserted during COUNT.
  - Required: next cycle busy=0, res_valid=0, count_enable=0; no done pulse.
- Settle clamp and zero steps:
  - Stimulus: cfg_settle=3, num_steps=0.
  - Required: exactly 16 low cycles before count_enable rises; exactly one result is produced.
- SCAN_DISCARD_FIRST_EN:
  - Stimulus: macro defined; counter model returns 5 then 8.
  - Required: the reported count is 8.

Source files
------------

// File: rtl/pulse_scan_pkg.sv
// Shared types, constants and the saturating adder for the
// threshold-scan sequencer (pulse_scan_ctrl, scan_result_fifo).
package pulse_scan_pkg;

    localparam int SCAN_DATA_W = 20;
    localparam int SCAN_CNT_W  = 24;
    localparam int SCAN_STEP_W = 5;
    localparam int MIN_SETTLE  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_PUSH   = 3'd4
    } scan_state_e;

    typedef struct packed {
        logic [SCAN_STEP_W-1:0] step;
        logic [SCAN_DATA_W-1:0] thr;
        logic [SCAN_CNT_W-1:0]  count;
    } scan_result_t;

    // Signed add with one guard bit, clamped to the signed range.
    function automatic logic [SCAN_DATA_W-1:0] sat_add(
        input logic [SCAN_DATA_W-1:0] a,
        input logic [SCAN_DATA_W-1:0] b
    );
        logic [SCAN_DATA_W:0] sum;
        sum = {a[SCAN_DATA_W-1], a} + {b[SCAN_DATA_W-1], b};
        if (sum[SCAN_DATA_W] != sum[SCAN_DATA_W-1]) begin
            sat_add = sum[SCAN_DATA_W]
                    ? {1'b1, {(SCAN_DATA_W-1){1'b0}}}
                    : {1'b0, {(SCAN_DATA_W-1){1'b1}}};
        end else begin
            sat_add = sum[SCAN_DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/scan_result_fifo.sv
// Small synchronous result FIFO with flush; a pop frees space for a
// push in the same cycle. DEPTH must be a power of two (>= 2).
module scan_result_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/pulse_scan_ctrl.sv
// Threshold-scan sequencer: ramps diff_threshold, gates the counter per
// step and queues results. Build option: SCAN_DISCARD_FIRST_EN.
module pulse_scan_ctrl
    import pulse_scan_pkg::*;
#(
    parameter int DATA_WIDTH    = SCAN_DATA_W,
    parameter int COUNTER_WIDTH = SCAN_CNT_W,
    parameter int STEP_W        = SCAN_STEP_W,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DATA_WIDTH-1:0]    cfg_thr_start,
    input  logic [DATA_WIDTH-1:0]    cfg_thr_step,
    input  logic [DATA_WIDTH-1:0]    cfg_abs_thr,
    input  logic [STEP_W-1:0]        cfg_num_steps,
    input  logic [23:0]              cfg_window,
    input  logic [7:0]               cfg_settle,
    output logic [DATA_WIDTH-1:0]    diff_threshold,
    output logic [DATA_WIDTH-1:0]    abs_threshold,
    output logic [23:0]              window_cycles,
    output logic                     count_enable,
    input  logic [COUNTER_WIDTH-1:0] cnt_pulse_count,
    input  logic                     cnt_count_valid,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [STEP_W-1:0]        res_step,
    output logic [DATA_WIDTH-1:0]    res_thr,
    output logic [COUNTER_WIDTH-1:0] res_count,
    output logic                     busy,
    output logic                     done
);

`ifdef SCAN_DISCARD_FIRST_EN
    localparam logic DISCARD_FIRST = 1'b1;
`else
    localparam logic DISCARD_FIRST = 1'b0;
`endif

    scan_state_e               state_q, state_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [STEP_W-1:0]         last_q, last_d;
    logic [DATA_WIDTH-1:0]     thr_q, thr_d;
    logic [DATA_WIDTH-1:0]     inc_q, inc_d;
    logic [DATA_WIDTH-1:0]     abs_q, abs_d;
    logic [23:0]               win_q, win_d;
    logic [7:0]                settle_q, settle_d;
    logic [7:0]                wait_q, wait_d;
    logic [COUNTER_WIDTH-1:0]  count_q, count_d;
    logic                      ce_q, ce_d;
    logic                      done_q, done_d;
    logic                      discard_q, discard_d;
    logic [DATA_WIDTH-1:0]     diff_out_q, diff_out_d;
    logic [DATA_WIDTH-1:0]     abs_out_q, abs_out_d;
    logic [23:0]               win_out_q, win_out_d;

    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_space;
    scan_result_t              wr_entry;
    scan_result_t              rd_entry;

    assign pop        = !fifo_empty && res_ready;
    assign fifo_space = !fifo_full || pop;
    assign wr_entry   = '{step: step_q, thr: thr_q, count: count_q};

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        last_d     = last_q;
        thr_d      = thr_q;
        inc_d      = inc_q;
        abs_d      = abs_q;
        win_d      = win_q;
        settle_d   = settle_q;
        wait_d     = wait_q;
        count_d    = count_q;
        ce_d       = ce_q;
        discard_d  = discard_q;
        diff_out_d = diff_out_q;
        abs_out_d  = abs_out_q;
        win_out_d  = win_out_q;
        done_d     = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    step_d   = '0;
                    thr_d    = cfg_thr_start;
                    inc_d    = cfg_thr_step;
                    abs_d    = cfg_abs_thr;
                    win_d    = cfg_window;
                    settle_d = (cfg_settle < 8'(MIN_SETTLE))
                             ? 8'(MIN_SETTLE) : cfg_settle;
                    last_d   = (cfg_num_steps == '0)
                             ? '0 : cfg_num_steps - 1'b1;
                end
            end
            ST_LOAD: begin
                diff_out_d = thr_q;
                abs_out_d  = abs_q;
                win_out_d  = win_q;
                wait_d     = settle_q - 8'd1;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (wait_q == '0) begin
                    state_d   = ST_COUNT;
                    ce_d      = 1'b1;
                    discard_d = DISCARD_FIRST;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_COUNT: begin
                if (cnt_count_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        count_d = cnt_pulse_count;
                        ce_d    = 1'b0;
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                if (fifo_space) begin
                    push = 1'b1;
                    if (step_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        thr_d   = sat_add(thr_q, inc_q);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d = ST_IDLE;
            ce_d    = 1'b0;
            done_d  = 1'b0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            last_q     <= '0;
            thr_q      <= '0;
            inc_q      <= '0;
            abs_q      <= '0;
            win_q      <= '0;
            settle_q   <= '0;
            wait_q     <= '0;
            count_q    <= '0;
            ce_q       <= 1'b0;
            done_q     <= 1'b0;
            discard_q  <= 1'b0;
            diff_out_q <= '0;
            abs_out_q  <= '0;
            win_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            last_q     <= last_d;
            thr_q      <= thr_d;
            inc_q      <= inc_d;
            abs_q      <= abs_d;
            win_q      <= win_d;
            settle_q   <= settle_d;
            wait_q     <= wait_d;
            count_q    <= count_d;
            ce_q       <= ce_d;
            done_q     <= done_d;
            discard_q  <= discard_d;
            diff_out_q <= diff_out_d;
            abs_out_q  <= abs_out_d;
            win_out_q  <= win_out_d;
        end
    end

    scan_result_fifo #(
        .WIDTH ($bits(scan_result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (res_ready),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign diff_threshold = diff_out_q;
    assign abs_threshold  = abs_out_q;
    assign window_cycles  = win_out_q;
    assign count_enable   = ce_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign res_valid      = !fifo_empty;
    assign res_step       = rd_entry.step;
    assign res_thr        = rd_entry.thr;
    assign res_count      = rd_entry.count;

endmodule

// File: tb/tb_pulse_scan_ctrl.sv
// Scoreboard bench for pulse_scan_ctrl: random scans against a
// step-list reference model, with a behavioural pulse-counter model.
module tb_pulse_scan_ctrl;

    localparam int DW = 20;
    localparam int CW = 24;
    localparam int SW = 5;
    localparam int TMAX = 524287;
    localparam int TMIN = -524288;

`ifdef SCAN_DISCARD_FIRST_EN
    localparam bit DISC = 1'b1;
`else
    localparam bit DISC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_thr_start = '0;
    logic [DW-1:0] cfg_thr_step = '0;
    logic [DW-1:0] cfg_abs_thr = '0;
    logic [SW-1:0] cfg_num_steps = '0;
    logic [23:0]   cfg_window = '0;
    logic [7:0]    cfg_settle = '0;
    logic [DW-1:0] diff_threshold;
    logic [DW-1:0] abs_threshold;
    logic [23:0]   window_cycles;
    logic          count_enable;
    logic [CW-1:0] cnt_pulse_count;
    logic          cnt_count_valid;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] res_step;
    logic [DW-1:0] res_thr;
    logic [CW-1:0] res_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pulse_scan_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_thr_start   (cfg_thr_start),
        .cfg_thr_step    (cfg_thr_step),
        .cfg_abs_thr     (cfg_abs_thr),
        .cfg_num_steps   (cfg_num_steps),
        .cfg_window      (cfg_window),
        .cfg_settle      (cfg_settle),
        .diff_threshold  (diff_threshold),
        .abs_threshold   (abs_threshold),
        .window_cycles   (window_cycles),
        .count_enable    (count_enable),
        .cnt_pulse_count (cnt_pulse_count),
        .cnt_count_valid (cnt_count_valid),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_step        (res_step),
        .res_thr         (res_thr),
        .res_count       (res_count),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        int            step;
        logic [DW-1:0] thr;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] cnt_tab[32];
    logic [DW-1:0] exp_thr[32];
    logic [CW-1:0] junk;
    logic [23:0]   exp_win;
    logic [DW-1:0] exp_abs;
    int            en_rises = 0;
    int            done_seen = 0;
    int            last_step = 0;
    int            ready_mode = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference ramp: repeated add, clamped to the signed 20-bit range.
    function automatic logic [DW-1:0] model_thr(int s, int inc, int k);
        longint t = s;
        for (int i = 0; i < k; i++) begin
            t = t + inc;
            if (t > TMAX) t = TMAX;
            if (t < TMIN) t = TMIN;
        end
        return DW'(t);
    endfunction

    task automatic scan(input logic [DW-1:0] ts, input logic [DW-1:0] inc,
                        input logic [DW-1:0] ab, input int n, input int win,
                        input int settle, input bit preset);
        int neff;
        neff = (n == 0) ? 1 : n;
        if (!preset) begin
            for (int k = 0; k < 32; k++) cnt_tab[k] = CW'($urandom);
            junk = CW'($urandom);
        end
        for (int k = 0; k < neff; k++) begin
            exp_thr[k] = model_thr($signed(ts), $signed(inc), k);
            exp_q.push_back('{k, exp_thr[k], cnt_tab[k]});
        end
        exp_win   = 24'(win);
        exp_abs   = ab;
        last_step = neff - 1;
        en_rises  = 0;
        done_seen = 0;
        @(posedge clk); #1;
        cfg_thr_start = ts;
        cfg_thr_step  = inc;
        cfg_abs_thr   = ab;
        cfg_num_steps = SW'(n);
        cfg_window    = 24'(win);
        cfg_settle    = 8'(settle);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config: the scan must use the latched copy.
        cfg_thr_start = DW'($urandom);
        cfg_thr_step  = DW'($urandom);
        cfg_abs_thr   = DW'($urandom);
        cfg_num_steps = SW'($urandom);
        cfg_window    = 24'($urandom_range(1, 3));
        cfg_settle    = 8'($urandom);
    endtask

    task automatic wait_idle(input int exp_done, input string tag);
        int n = 0;
        while ((busy || res_valid) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_finish"}, 64'(n < 20000), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_done_count"}, 64'(done_seen), 64'(exp_done));
    endtask

    // Pulse-counter model: one count_valid per window while enabled.
    initial begin
        int  win = 0;
        int  nwin = 0;
        int  k = 0;
        bit  prev = 1'b0;
        cnt_count_valid = 1'b0;
        cnt_pulse_count = '0;
        forever begin
            @(posedge clk); #1;
            cnt_count_valid = 1'b0;
            if (count_enable) begin
                if (!prev) begin
                    win = 0;
                    nwin = 0;
                    k = en_rises;
                    en_rises++;
                    check("thr_at_enable", 64'(diff_threshold),
                          64'(exp_thr[k]));
                    check("abs_at_enable", 64'(abs_threshold), 64'(exp_abs));
                    check("win_at_enable", 64'(window_cycles), 64'(exp_win));
                end
                win++;
                if (win >= int'(window_cycles)) begin
                    cnt_count_valid = 1'b1;
                    cnt_pulse_count = (DISC && nwin == 0) ? junk : cnt_tab[k];
                    nwin++;
                    win = 0;
                end
            end else if (rst_n && $urandom_range(0, 7) == 0) begin
                cnt_count_valid = 1'b1;
                cnt_pulse_count = CW'($urandom);
            end
            prev = count_enable;
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted result.
    initial begin
        bit            hold = 1'b0;
        logic [63:0]   prev_res = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    done_seen++;
                    check("done_with_result", 64'(res_valid), 64'(1));
                    if (ready_mode == 0)
                        check("done_head_step", 64'(res_step),
                              64'(last_step));
                end
                if (hold && res_valid)
                    check("res_stable", 64'({res_step, res_thr, res_count}),
                          prev_res);
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got step %0d, none expected",
                                 res_step);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_entry",
                              64'({res_step, res_thr, res_count}),
                              64'({SW'(e.step), e.thr, e.cnt}));
                    end
                end
                hold     = res_valid && !res_ready;
                prev_res = 64'({res_step, res_thr, res_count});
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_count_enable", 64'(count_enable), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_diff_thr", 64'(diff_threshold), 64'(0));
        check("rst_abs_thr", 64'(abs_threshold), 64'(0));
        check("rst_window", 64'(window_cycles), 64'(0));
        check("rst_res", 64'({res_step, res_thr, res_count}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic scan with fixed counts.
        ready_mode = 0;
        cnt_tab[0] = 7; cnt_tab[1] = 9; cnt_tab[2] = 11;
        junk = 24'd3;
        scan(20'd100, 20'd50, 20'd33, 3, 64, 20, 1'b1);
        wait_idle(1, "basic");

        // Positive and negative saturation.
        scan(20'h7FF00, 20'h00200, 20'd1, 3, 5, 16, 1'b0);
        check("sat_model_s1", 64'(exp_thr[1]), 64'(20'h7FFFF));
        wait_idle(1, "sat_pos");
        scan(20'h80100, 20'hFFE00, 20'd1, 3, 4, 17, 1'b0);
        wait_idle(1, "sat_neg");

        // Backpressure: FIFO fills with steps 0..3, step 4 stalls.
        ready_mode = 2;
        scan(20'd10, 20'd3, 20'd5, 6, 3, 16, 1'b0);
        n = 0;
        while (!(en_rises == 5 && !count_enable) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_reach_stall", 64'(n < 5000), 64'(1));
        repeat (40) @(posedge clk);
        #1;
        check("bp_ce_low", 64'(count_enable), 64'(0));
        check("bp_busy", 64'(busy), 64'(1));
        check("bp_steps_started", 64'(en_rises), 64'(5));
        check("bp_res_valid", 64'(res_valid), 64'(1));
        ready_mode = 0;
        wait_idle(1, "bp");

        // Abort during COUNT with results still queued.
        ready_mode = 2;
        scan(20'd200, 20'd7, 20'd9, 6, 30, 16, 1'b0);
        n = 0;
        while (!(en_rises == 3 && count_enable) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_count", 64'(n < 5000), 64'(1));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_res_valid", 64'(res_valid), 64'(0));
        check("abort_ce", 64'(count_enable), 64'(0));
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_seen), 64'(0));

        // Abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_idle", 64'(busy), 64'(0));

        // Settle clamp and zero steps: LOAD plus 16 settle cycles.
        scan(20'd42, 20'd1, 20'd2, 0, 4, 3, 1'b0);
        n = 0;
        while (!count_enable && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("settle_clamp_cycles", 64'(n), 64'(1 + 16));
        wait_idle(1, "zero_steps");

        // First-window discard (or plain capture when disabled).
        cnt_tab[0] = 24'd8;
        junk = 24'd5;
        scan(20'd0, 20'd0, 20'd0, 1, 6, 16, 1'b1);
        wait_idle(1, "discard");

        // Random scans with random consumer backpressure.
        ready_mode = 1;
        for (int r = 0; r < 10; r++) begin
            scan(DW'($urandom),
                 (r % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 400)),
                 DW'($urandom), $urandom_range(0, 7),
                 $urandom_range(2, 9), $urandom_range(0, 40), 1'b0);
            wait_idle(1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
